// File: rtl/pea_result_drain_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pea_result_drain_if : FIFO pop/data and output-beat handshake bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface pea_result_drain_if #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_W     = 5
);
    logic [CNT_W-1:0]     result_pop;
    logic [CNT_W-1:0]     status_pop;
    logic [WIDTH-1:0]     result_data;
    logic [WIDTH-1:0]     status_data;
    logic                 rd_en_result;
    logic                 rd_en_status;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        input  result_pop, status_pop, result_data, status_data, out_ready,
        output rd_en_result, rd_en_status, out_data, out_valid, out_last
    );

    modport slave (
        output result_pop, status_pop, result_data, status_data, out_ready,
        input  rd_en_result, rd_en_status, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/pea_result_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pea_result_drain : pops result/status pairs and sends them as 3 beats. Rev 1.0
// ---------------------------------------------------------------------------
module pea_result_drain #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    pea_result_drain_if.master  bus,
    output logic [15:0]         pkt_count,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ZERO_POP  = '0;
    localparam logic [1:0]       LAST_BEAT = 2'd2;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sts_q;
    logic [1:0]       beat_idx;
    logic             pops_ready;
    logic             send_active;
    logic             beat_xfer;
    logic             last_xfer;
    logic             unused_sts;

    assign pops_ready  = (bus.result_pop != ZERO_POP) && (bus.status_pop != ZERO_POP);
    assign send_active = (state == SEND);
    assign beat_xfer   = send_active && bus.out_ready;
    assign last_xfer   = beat_xfer && (beat_idx == LAST_BEAT);
    assign busy        = (state != IDLE);
    assign unused_sts  = ^sts_q[WIDTH-1:OUT_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Populations only matter in IDLE and on the final-beat handoff.
    always_comb begin
        state_nxt        = state;
        bus.rd_en_result = 1'b0;
        bus.rd_en_status = 1'b0;
        case (state)
            IDLE: begin
                if (pops_ready) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bus.rd_en_result = 1'b1;
                bus.rd_en_status = 1'b1;
                state_nxt        = LATCH;
            end
            LATCH: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (last_xfer) begin
                    state_nxt = pops_ready ? READ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q     <= '0;
            sts_q     <= '0;
            beat_idx  <= 2'd0;
            pkt_count <= 16'd0;
        end else begin
            if (state == LATCH) begin
                res_q    <= bus.result_data;
                sts_q    <= bus.status_data;
                beat_idx <= 2'd0;
            end else if (beat_xfer) begin
                if (beat_idx == LAST_BEAT) begin
                    beat_idx  <= 2'd0;
                    pkt_count <= pkt_count + 16'd1;
                end else begin
                    beat_idx <= beat_idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        bus.out_valid = send_active;
        bus.out_last  = send_active && (beat_idx == LAST_BEAT);
        bus.out_data  = '0;
        if (send_active) begin
            case (beat_idx)
                2'd0:    bus.out_data = sts_q[OUT_WIDTH-1:0];
                2'd1:    bus.out_data = res_q[2*OUT_WIDTH-1:OUT_WIDTH];
                default: bus.out_data = res_q[OUT_WIDTH-1:0];
            endcase
        end
    end
endmodule
`default_nettype wire
